// File: rtl/booth_arbiter.sv
// Round-robin front end that shares one multi-cycle Booth multiplier among four requesters.
// Optional watchdog: define BOOTH_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module booth_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic [0:0]     clk,
    input  logic [0:0]     rst_n,
    input  logic [3:0]     req_valid,
    input  logic [4*W-1:0] req_a,
    input  logic [4*W-1:0] req_b,
    output logic [3:0]     req_ack,
    output logic [3:0]     rsp_valid,
    output logic [2*W-1:0] rsp_data,
    output logic [0:0]     rsp_err,
    output logic [0:0]     busy,
    output logic [0:0]     mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [0:0]     mul_done,
    input  logic [2*W-1:0] mul_product,
    output logic [1:0]     dbg_state
);
    // Handshake: req_valid[i] stays high until req_ack[i] pulses; the operands are
    // captured on the clock edge that ends the ack cycle. rsp_valid pulses once per grant.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         r_state;
    logic [1:0]     r_ptr;
    logic [1:0]     r_gidx;
    logic [W-1:0]   r_mul_a;
    logic [W-1:0]   r_mul_b;
    logic           r_mul_start;
    logic [3:0]     r_rsp_valid;
    logic [2*W-1:0] r_rsp_data;
    logic           w_found;
    logic [1:0]     w_gidx;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  r_cnt;
    logic           r_rsp_err;
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    // First pending requester at or above the pointer, wrapping modulo 4.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req_valid[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_gidx  = r_ptr + 2'(k);
            end
        end
    end

    // The grant is combinational, so it is gated by reset to keep outputs quiet while held.
    assign req_ack   = (rst_n && (r_state == IDLE) && w_found) ? (4'b0001 << w_gidx) : 4'b0000;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != IDLE);
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_mul_a     <= req_a[w_gidx*W +: W];
                        r_mul_b     <= req_b[w_gidx*W +: W];
                        r_gidx      <= w_gidx;
                        r_ptr       <= w_gidx + 2'd1;
                        r_mul_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mul_start <= 1'b0;
                    r_state     <= WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    r_cnt       <= '0;
`endif
                end
                WAIT: begin
                    // A completion in the expiry cycle takes priority over the watchdog.
                    if (mul_done) begin
                        r_rsp_valid <= 4'b0001 << r_gidx;
                        r_rsp_data  <= mul_product;
                        r_state     <= RESP;
                    end
`ifdef BOOTH_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 4'b0001 << r_gidx;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_data  <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    r_rsp_err   <= 1'b0;
`endif
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: randomized requesters, a latency-programmable multiplier model,
// and a monitor that scores grants and responses against a round-robin reference model.
module tb_booth_arbiter;
  localparam int W = 8;
  localparam int TIMEOUT = 64;
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [3:0] req_valid;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0] req_ack;
  logic [3:0] rsp_valid;
  logic [2*W-1:0] rsp_data;
  logic rsp_err;
  logic busy;
  logic mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic mul_done;
  logic [2*W-1:0] mul_product;
  logic [1:0] dbg_state;

  booth_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / shared state ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_fail = 0;
  logic [18:0] exp_q[$];          // {requester[1:0], err, product[15:0]}
  int m_ptr = 0;
  int starts = 0;
  int ack_cyc = 0;
  int done_cyc = -10;
  logic [7:0] exp_ma, exp_mb;
  logic [3:0] last_ack = '0;

  int mul_lat = 4;
  bit mul_hang = 1'b0;
  bit force_done = 1'b0;
  bit chk_busy = 1'b0;
  bit tmo_flag = 1'b0;
  bit final_req = 1'b0;
  bit final_done = 1'b0;

  // ---------------- multiplier model ----------------
  int mcnt = 0;
  bit mbusy = 1'b0;
  int mpa, mpb, mprod;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mbusy = 1'b0;
      mcnt = 0;
      mul_done = 1'b0;
      mul_product = '0;
    end else begin
      mul_done = force_done;
      mul_product = '0;
      if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin
          mbusy = 1'b0;
          if (!mul_hang) begin
            mpa = $signed(mul_a);
            mpb = $signed(mul_b);
            mprod = mpa * mpb;
            mul_done = 1'b1;
            mul_product = mprod[15:0];
            done_cyc = cyc;
          end
        end
      end
      if (mul_start) begin
        mbusy = 1'b1;
        mcnt = mul_lat;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int g, pa, pb, prod;
  bit e_err;
  logic [18:0] ent;
  logic [15:0] e_data;
  always @(negedge clk) begin
    last_ack = req_ack;
    if (!rst_n) begin
      check("reset_outputs", {req_ack, rsp_valid, rsp_data, rsp_err, busy, mul_start,
                              mul_a, mul_b, dbg_state}, 64'd0);
      exp_q.delete();
      m_ptr = 0;
      starts = 0;
    end else begin
      if (mul_start) begin
        starts++;
        check("mul_a_latched", mul_a, exp_ma);
        check("mul_b_latched", mul_b, exp_mb);
      end
      if (req_ack != 0) begin
        g = -1;
        for (int k = 3; k >= 0; k--) if (req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        check("grant", req_ack, (g < 0) ? 0 : (1 << g));
        check("single_outstanding", exp_q.size(), 0);
        check("ack_rsp_exclusive", rsp_valid, 0);
        if (g >= 0) begin
          m_ptr = (g + 1) % 4;
          exp_ma = req_a[g*8 +: 8];
          exp_mb = req_b[g*8 +: 8];
          pa = $signed(exp_ma);
          pb = $signed(exp_mb);
          prod = pa * pb;
          e_err = TO_EN && (mul_hang || mul_lat > TIMEOUT);
          e_data = e_err ? 16'h0 : prod[15:0];
          exp_q.push_back({2'(g), e_err, e_data});
          ack_cyc = cyc;
          starts = 0;
        end
      end
      if (rsp_valid != 0) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", rsp_valid, 0);
        end else begin
          ent = exp_q.pop_front();
          check("rsp_valid", rsp_valid, 4'b0001 << ent[18:17]);
          check("rsp_data", rsp_data, ent[15:0]);
          check("rsp_err", rsp_err, ent[16]);
          check("start_pulses", starts, 1);
          if (ent[16]) check("timeout_latency", cyc, ack_cyc + TIMEOUT + 2);
          else check("rsp_latency", cyc, done_cyc + 1);
        end
      end
      if (chk_busy) check("busy_hold", busy, 1);
    end
    if (final_req && !final_done) begin
      check("queue_drained", exp_q.size(), 0);
      check("no_drain_timeout", tmo_flag, 0);
      final_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~last_ack;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic raise(int i, logic [7:0] a, logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic drain();
    int n = 0;
    while ((req_valid != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) tmo_flag = 1'b1;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    cycles(3);
    rst_n = 1'b1;
    cycle();

    // single request, 10-cycle multiply: 3 * -2 = 0xFFFA
    mul_lat = 10;
    raise(0, 8'h03, 8'hFE);
    drain();

    // all four after reset: 0,1,2,3; then 0 and 2: 0 then 2
    do_reset();
    mul_lat = 3;
    for (int i = 0; i < 4; i++) raise(i, 8'($urandom), 8'($urandom));
    drain();
    raise(0, 8'h7F, 8'h80);
    raise(2, 8'h80, 8'h80);
    drain();

    // spurious mul_done while idle must be ignored
    force_done = 1'b1;
    cycles(2);
    force_done = 1'b0;
    mul_lat = 6;
    raise(1, 8'hFF, 8'hFF);
    drain();

    // randomized rounds, including requests raised while busy
    for (int r = 0; r < 30; r++) begin
      logic [3:0] mask;
      mul_lat = $urandom_range(1, 12);
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (mask[i] && !req_valid[i]) raise(i, 8'($urandom), 8'($urandom));
      for (int t = 0; t < 8; t++) begin
        cycle();
        if ($urandom_range(0, 3) == 0) begin
          int j = $urandom_range(0, 3);
          if (!req_valid[j]) raise(j, 8'($urandom), 8'($urandom));
        end
      end
      drain();
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    mul_lat = TIMEOUT + 1;
    raise(3, 8'h12, 8'h34);
    drain();
    mul_lat = TIMEOUT;
    raise(0, 8'h81, 8'h05);
    drain();
`endif

    // hang in WAIT, pend 1 and 3, then reset: requester 1 must win first
    mul_hang = 1'b1;
    raise(2, 8'h11, 8'h22);
    cycles(3);
    chk_busy = 1'b1;
    cycles(TO_EN ? 20 : 80);
    chk_busy = 1'b0;
    raise(1, 8'hC3, 8'h05);
    raise(3, 8'h09, 8'hF7);
    cycles(2);
    mul_hang = 1'b0;
    mul_lat = 5;
    do_reset();
    drain();

    final_req = 1'b1;
    cycles(4);
    if (!final_done) begin
      n_fail++;
      $display("FAIL final_check: monitor did not complete final comparisons");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter W, default 8: operand width of the shared Booth multiplier; product width is 2W.
REQ-002 Parameter TIMEOUT, default 64: watchdog limit in clk cycles (used only with BOOTH_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  4  per-requester request; held high until the matching req_ack is seen.
REQ-006 req_a  in  4*W  requester i multiplicand in bits [i*W +: W], two's complement.
REQ-007 req_b  in  4*W  requester i multiplier in bits [i*W +: W], two's complement.
REQ-008 req_ack  out  4  one-hot, one-cycle grant pulse; operands are sampled at the edge ending that cycle.
REQ-009 rsp_valid  out  4  one-hot, one-cycle result pulse to the granted requester.
REQ-010 rsp_data  out  2W  product, valid only while any rsp_valid bit is high.
REQ-011 rsp_err  out  1  high with rsp_valid when the operation timed out.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-014 mul_a, mul_b  out  W each  latched operands, stable from ISSUE through WAIT.
REQ-015 mul_done  in  1  multiplier completion, level or pulse, sampled only in WAIT.
REQ-016 mul_product  in  2W  multiplier result, sampled in the same cycle as mul_done.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if req_valid != 0, assert req_ack[g] combinationally, latch operands and index g, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Selection SHALL be round-robin: g is the first asserted index found by searching upward from ptr, modulo 4.
REQ-020 On each grant, ptr SHALL update to (g+1) mod 4.
REQ-021 ISSUE: assert mul_start for exactly one cycle, then go to WAIT unconditionally.
REQ-022 WAIT: when mul_done=1, capture mul_product and go to RESP; otherwise stay in WAIT.
REQ-023 RESP: drive rsp_valid[g]=1 and rsp_data=captured product for one cycle, then go to IDLE.
REQ-024 Latency: ack in cycle c; mul_start in c+1; if mul_done is sampled in cycle d, rsp_valid is in d+1; the earliest next ack is d+2.
REQ-025 mul_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-026 Requests arriving in non-IDLE states SHALL wait; they are not lost and not acked.
REQ-027 At most one operation SHALL be outstanding; req_ack and rsp_valid are never asserted in the same cycle.
REQ-028 The block performs no arithmetic; product bits pass through unmodified.

Reset
REQ-029 While rst_n=0: state=IDLE, ptr=0, and all outputs are 0, including mul_a, mul_b and rsp_data.
REQ-030 Reset in any state SHALL abort the in-flight operation without a response; requesters re-request after reset.

Configuration
REQ-031 Macro BOOTH_ARB_TIMEOUT_EN, when defined: a counter clears on entry to WAIT and increments each WAIT cycle; if it reaches TIMEOUT without mul_done, go to RESP with rsp_err=1 and rsp_data=0.
REQ-032 With BOOTH_ARB_TIMEOUT_EN, if mul_done=1 in the expiry cycle, mul_done wins: normal product and rsp_err=0.
REQ-033 Without BOOTH_ARB_TIMEOUT_EN: no counter is built, rsp_err is tied 0, and WAIT waits indefinitely.

Verification
REQ-034 W=8; req_valid=0001, a=0x03, b=0xFE; model returns done with 0xFFFA 10 cycles after mul_start -> req_ack=0001 one cycle, one mul_start pulse, rsp_valid=0001 with rsp_data=0xFFFA one cycle after done.
REQ-035 All four req_valid high after reset -> grant order 0,1,2,3; then req 0 and 2 high -> grant order 0 then 2.
REQ-036 mul_done pulsed while in IDLE, then a request issued -> the spurious done is ignored and no rsp_valid occurs before the real done.
REQ-037 With macro, mul_done never asserted -> rsp_valid with rsp_err=1 and rsp_data=0 after 64 WAIT cycles; without macro -> busy stays 1.
REQ-038 With macro, mul_done asserted in the exact expiry cycle -> rsp_err=0 and the product is delivered.
REQ-039 rst_n pulled low in WAIT -> all outputs 0 immediately; after release, requests 1 and 3 are pending -> requester 1 is granted first (ptr=0).
